// File: rtl/prbs_amp_offset_scaler_pkg.sv
// Shared definitions for the PRBS amplitude/offset scaler: mute FSM
// encodings, gain/timeout constants and saturation limits.
package prbs_amp_offset_scaler_pkg;

  // Mute FSM states; the encoding is visible on the mute_state output.
  typedef enum logic [1:0] {
    MUTE_ACTIVE   = 2'b00,
    MUTE_MUTING   = 2'b01,
    MUTE_MUTED    = 2'b10,
    MUTE_UNMUTING = 2'b11
  } mute_state_e;

  // Unity amplitude in unsigned Q1.15.
  localparam logic [15:0] AMP_UNITY = 16'h8000;

  // Mute gain runs 0..GAIN_STEPS; GAIN_STEPS means pass-through.
  localparam int GAIN_STEPS = 64;
  localparam int GAIN_W     = 7;
  localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(GAIN_STEPS);
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1);

  // Consecutive busy cycles a pending config may wait before a forced apply.
  localparam int CFG_TIMEOUT = 64;
  localparam int TIMER_W     = 6;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CFG_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  // Saturation limits of the 18-bit offset sum and the matching DAC codes.
  localparam logic signed [17:0] SAT_HI      = 18'sd32767;
  localparam logic signed [17:0] SAT_LO      = -18'sd32768;
  localparam logic [15:0]        CODE_MAX    = 16'h7FFF;
  localparam logic [15:0]        CODE_MIN    = 16'h8000;
  localparam logic [15:0]        COUNT_LIMIT = 16'hFFFF;

  // Amplitudes above unity are treated as unity.
  function automatic logic [15:0] clamp_amp(input logic [15:0] amp);
    return (amp > AMP_UNITY) ? AMP_UNITY : amp;
  endfunction

endpackage

// File: rtl/prbs_amp_offset_scaler_mute_ramp.sv
// Mute FSM with a linear gain ramp. The gain steps by one every cycle
// towards 0 while load_protect_i is high and towards GAIN_STEPS while it is
// low, so a request reversal simply turns the ramp around at the current gain.
module prbs_mute_ramp
  import prbs_amp_offset_scaler_pkg::*;
(
  input  logic              dac_clk,
  input  logic              reset_n,
  input  logic              load_protect_i,
  output logic [GAIN_W-1:0] gain_o,
  output mute_state_e       state_o
);

  mute_state_e       state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;

  // State and gain registers; reset lands in ACTIVE at full gain.
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      state_q <= MUTE_ACTIVE;
      gain_q  <= GAIN_MAX;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // Next state and gain step; ramp advances every cycle regardless of data.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      MUTE_ACTIVE: begin
        if (load_protect_i) begin
          gain_d  = gain_q - GAIN_ONE;
          state_d = MUTE_MUTING;
        end
      end
      MUTE_MUTING: begin
        if (load_protect_i) begin
          gain_d  = gain_q - GAIN_ONE;
          state_d = (gain_q == GAIN_ONE) ? MUTE_MUTED : MUTE_MUTING;
        end else begin
          gain_d  = gain_q + GAIN_ONE;
          state_d = (gain_q == GAIN_MAX - GAIN_ONE) ? MUTE_ACTIVE : MUTE_UNMUTING;
        end
      end
      MUTE_MUTED: begin
        if (!load_protect_i) begin
          gain_d  = gain_q + GAIN_ONE;
          state_d = MUTE_UNMUTING;
        end
      end
      MUTE_UNMUTING: begin
        if (!load_protect_i) begin
          gain_d  = gain_q + GAIN_ONE;
          state_d = (gain_q == GAIN_MAX - GAIN_ONE) ? MUTE_ACTIVE : MUTE_UNMUTING;
        end else begin
          gain_d  = gain_q - GAIN_ONE;
          state_d = (gain_q == GAIN_ONE) ? MUTE_MUTED : MUTE_MUTING;
        end
      end
      default: begin
        state_d = MUTE_ACTIVE;
        gain_d  = GAIN_MAX;
      end
    endcase
  end

  assign gain_o  = gain_q;
  assign state_o = state_q;

endmodule

// File: rtl/prbs_amp_offset_scaler.sv
// Four-stage DAC sample scaler: register input, Q1.15 amplitude scale with
// round-half-up, offset add with saturation, then mute gain.
// Handshake: in_valid qualifies in_data and there is no backpressure; every
// valid sample emerges on out_valid/out_data exactly four cycles later.
module prbs_amp_offset_scaler
  import prbs_amp_offset_scaler_pkg::*;
(
  input  logic        dac_clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [15:0] amplitude_cfg,
  input  logic [15:0] dc_offset_cfg,
  input  logic        cfg_update,
  input  logic        load_protect,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        sat_flag,
  output logic [15:0] sat_count,
  output logic        cfg_pending,
  output logic [1:0]  mute_state
);

  // Configuration: shadow copies, applied copies, pending flag and timeout.
  logic [15:0]        sh_amp_q, sh_amp_d, sh_off_q, sh_off_d;
  logic [15:0]        amp_q, amp_d, off_q, off_d;
  logic               pending_q, pending_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  // Pipeline stages.
  logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic               s3_valid_q, s3_valid_d, out_valid_q, out_valid_d;
  logic [15:0]        s1_data_q, s1_data_d;
  logic [16:0]        s2_data_q, s2_data_d;
  logic [15:0]        s3_data_q, s3_data_d;
  logic [15:0]        out_data_q, out_data_d;

  // Saturation tracking.
  logic               sat_flag_q, sat_flag_d;
  logic [15:0]        sat_count_q, sat_count_d;

  // Arithmetic intermediates.
  logic signed [32:0] prod2, round2;
  logic signed [17:0] sum3;
  logic signed [22:0] prod4;
  logic               sat_hit, sat_event;
  logic               unused_bits;

  logic [GAIN_W-1:0]  gain;
  mute_state_e        ramp_state;

  prbs_mute_ramp u_mute_ramp (
    .dac_clk        (dac_clk),
    .reset_n        (reset_n),
    .load_protect_i (load_protect),
    .gain_o         (gain),
    .state_o        (ramp_state)
  );

  // Shadow capture and apply: a new update restarts the wait; apply on the
  // first idle input cycle, or forcibly after CFG_TIMEOUT busy cycles.
  always_comb begin
    sh_amp_d  = sh_amp_q;
    sh_off_d  = sh_off_q;
    amp_d     = amp_q;
    off_d     = off_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    if (cfg_update) begin
      sh_amp_d  = amplitude_cfg;
      sh_off_d  = dc_offset_cfg;
      pending_d = 1'b1;
      timer_d   = '0;
    end else if (pending_q) begin
      if (!in_valid || (timer_q == TIMER_LAST)) begin
        amp_d     = clamp_amp(sh_amp_q);
        off_d     = sh_off_q;
        pending_d = 1'b0;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + TIMER_ONE;
      end
    end
  end

  // Datapath next values for all four stages plus saturation bookkeeping.
  always_comb begin
    s1_valid_d = in_valid;
    s1_data_d  = in_data;

    prod2      = $signed({{17{s1_data_q[15]}}, s1_data_q}) * $signed({17'b0, amp_q});
    round2     = prod2 + 33'sd16384;
    s2_valid_d = s1_valid_q;
    s2_data_d  = round2[31:15];

    sum3       = $signed({s2_data_q[16], s2_data_q}) + $signed({{2{off_q[15]}}, off_q});
    sat_hit    = 1'b0;
    s3_data_d  = sum3[15:0];
    if (sum3 > SAT_HI) begin
      s3_data_d = CODE_MAX;
      sat_hit   = 1'b1;
    end else if (sum3 < SAT_LO) begin
      s3_data_d = CODE_MIN;
      sat_hit   = 1'b1;
    end
    s3_valid_d = s2_valid_q;

    sat_event   = s2_valid_q & sat_hit;
    sat_flag_d  = sat_flag_q | sat_event;
    sat_count_d = sat_count_q;
    if (sat_event && (sat_count_q != COUNT_LIMIT)) begin
      sat_count_d = sat_count_q + 16'd1;
    end

    prod4       = $signed({{7{s3_data_q[15]}}, s3_data_q}) * $signed({16'b0, gain});
    out_valid_d = s3_valid_q;
    out_data_d  = prod4[21:6];
  end

  // Bits dropped by the fixed-point shifts.
  assign unused_bits = ^{round2[32], round2[14:0], prod4[22], prod4[5:0]};

  // Config registers; reset restores unity gain and zero offset.
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      sh_amp_q  <= AMP_UNITY;
      sh_off_q  <= 16'h0000;
      amp_q     <= AMP_UNITY;
      off_q     <= 16'h0000;
      pending_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      sh_amp_q  <= sh_amp_d;
      sh_off_q  <= sh_off_d;
      amp_q     <= amp_d;
      off_q     <= off_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  // Pipeline and saturation registers; reset flushes everything in flight.
  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_data_q   <= '0;
      s2_data_q   <= '0;
      s3_data_q   <= '0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      s1_data_q   <= s1_data_d;
      s2_data_q   <= s2_data_d;
      s3_data_q   <= s3_data_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign sat_flag    = sat_flag_q;
  assign sat_count   = sat_count_q;
  assign cfg_pending = pending_q;
  assign mute_state  = ramp_state;

endmodule

// File: tb/tb_prbs_amp_offset_scaler.sv
// Bench for prbs_amp_offset_scaler: directed scenarios plus random traffic,
// compared every cycle against a cycle-indexed arithmetic reference model.
module tb_prbs_amp_offset_scaler;

  logic        dac_clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] amplitude_cfg;
  logic [15:0] dc_offset_cfg;
  logic        cfg_update;
  logic        load_protect;
  logic        out_valid;
  logic [15:0] out_data;
  logic        sat_flag;
  logic [15:0] sat_count;
  logic        cfg_pending;
  logic [1:0]  mute_state;

  prbs_amp_offset_scaler dut (
    .dac_clk       (dac_clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .amplitude_cfg (amplitude_cfg),
    .dc_offset_cfg (dc_offset_cfg),
    .cfg_update    (cfg_update),
    .load_protect  (load_protect),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .sat_flag      (sat_flag),
    .sat_count     (sat_count),
    .cfg_pending   (cfg_pending),
    .mute_state    (mute_state)
  );

  // clock / reset
  always #4 dac_clk = ~dac_clk;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [15:0] exp_q[$];

  // reference model: per-cycle history and spec-level configuration state
  localparam int HMAX = 4096;
  int hv   [0:HMAX-1];
  int hd   [0:HMAX-1];
  int hamp [0:HMAX-1];
  int hoff [0:HMAX-1];
  int hg   [0:HMAX-1];
  int m_amp = 32768, m_off = 0, m_sh_amp = 32768, m_sh_off = 0;
  int m_pcount = 0, m_g = 64, m_sat = 0, last_rst = -100;
  bit m_pend = 0, m_down = 0, m_flag = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int s16(input int x);
    int v;
    v = x & 32'hFFFF;
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic longint floordiv(input longint x, input longint n);
    if (x >= 0) return x / n;
    return -((-x + n - 1) / n);
  endfunction

  // amplitude scale (round half up), offset add, clip to the 16-bit range
  function automatic int stage3(input int d, input int amp, input int off, output bit sat);
    longint scaled;
    int s;
    scaled = floordiv(longint'(d) * longint'(amp) + 64'sd16384, 64'sd32768);
    s = int'(scaled) + off;
    sat = 0;
    if (s > 32767) begin s = 32767; sat = 1; end
    else if (s < -32768) begin s = -32768; sat = 1; end
    return s;
  endfunction

  function automatic int exp_state();
    if (m_g == 64) return 0;
    if (m_g == 0) return 2;
    return m_down ? 1 : 3;
  endfunction

  // compare every observable output for the current cycle
  task automatic check_cycle();
    bit sat;
    bit ev;
    int s3;
    int e;
    int m;
    m = cyc;
    if (last_rst == m - 1) begin
      m_sat  = 0;
      m_flag = 0;
      exp_q.delete();
      check_val("rst_out_data", 32'(out_data), 32'd0);
    end else if (m - 3 > last_rst) begin
      if (hv[m-3] != 0) begin
        s3 = stage3(hd[m-3], hamp[m-2], hoff[m-1], sat);
        if (sat) begin
          m_flag = 1;
          if (m_sat < 65535) m_sat++;
        end
      end
    end
    ev = 0;
    if (m - 4 > last_rst) ev = (hv[m-4] != 0);
    if (ev) begin
      s3 = stage3(hd[m-4], hamp[m-3], hoff[m-2], sat);
      e  = int'(floordiv(longint'(s3) * longint'(hg[m-1]), 64));
      exp_q.push_back(16'(e));
    end
    check_val("out_valid", 32'(out_valid), 32'(ev));
    if (out_valid && exp_q.size() > 0) check_val("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    check_val("sat_count", 32'(sat_count), 32'(m_sat));
    check_val("sat_flag", 32'(sat_flag), 32'(m_flag));
    check_val("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    check_val("mute_state", 32'(mute_state), 32'(exp_state()));
  endtask

  // driver: apply one cycle of inputs, advance the model, then check
  task automatic tick(input bit v, input int d, input bit upd, input int a, input int o,
                      input bit lp, input bit rn);
    if (cyc >= HMAX - 2) begin
      $display("FAIL history_overflow cyc=%0d limit=%0d", cyc, HMAX);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "history overflow");
    end
    in_valid      = v;
    in_data       = d[15:0];
    cfg_update    = upd;
    amplitude_cfg = a[15:0];
    dc_offset_cfg = o[15:0];
    load_protect  = lp;
    reset_n       = rn;
    hv[cyc]   = v;
    hd[cyc]   = s16(d);
    hamp[cyc] = m_amp;
    hoff[cyc] = m_off;
    hg[cyc]   = m_g;
    if (!rn) begin
      last_rst = cyc;
      m_amp = 32768; m_off = 0; m_sh_amp = 32768; m_sh_off = 0;
      m_pend = 0; m_pcount = 0; m_g = 64; m_down = 0;
    end else begin
      if (upd) begin
        m_sh_amp = a & 32'hFFFF;
        m_sh_off = s16(o);
        m_pend   = 1;
        m_pcount = 0;
      end else if (m_pend) begin
        m_pcount++;
        if (!v || m_pcount == 64) begin
          m_amp  = (m_sh_amp > 32768) ? 32768 : m_sh_amp;
          m_off  = m_sh_off;
          m_pend = 0;
        end
      end
      if (lp) m_g = (m_g > 0) ? m_g - 1 : 0;
      else    m_g = (m_g < 64) ? m_g + 1 : 64;
      m_down = lp;
    end
    @(posedge dac_clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n, input bit lp);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, lp, 1);
  endtask

  task automatic stream(input int n, input int d, input bit lp);
    for (int i = 0; i < n; i++) tick(1, d, 0, 0, 0, lp, 1);
  endtask

  initial begin
    int pend_n;
    bit lp_lvl;
    bit v;
    bit upd;
    int a;
    int o;

    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);

    // unity defaults pass the sample through
    stream(8, 16'h1234, 0);
    check_val("dir_unity", 32'(out_data), 32'h1234);

    // half amplitude applied in a gap
    tick(0, 0, 1, 16'h4000, 0, 0, 1);
    idle(2, 0);
    stream(6, 16'h7FFF, 0);
    check_val("dir_half", 32'(out_data), 32'h4000);

    // amplitude above unity behaves as unity
    tick(0, 0, 1, 16'hFFFF, 0, 0, 1);
    idle(2, 0);
    stream(6, 16'h7FFF, 0);
    check_val("dir_amp_clamp", 32'(out_data), 32'h7FFF);

    // positive then negative saturation
    tick(0, 0, 1, 16'h8000, 16'h7000, 0, 1);
    idle(2, 0);
    tick(1, 16'h2000, 0, 0, 0, 0, 1);
    idle(3, 0);
    check_val("dir_sat_hi", 32'(out_data), 32'h7FFF);
    check_val("dir_sat_flag", 32'(sat_flag), 32'd1);
    check_val("dir_sat_cnt1", 32'(sat_count), 32'd1);
    tick(0, 0, 1, 16'h8000, 16'hF000, 0, 1);
    idle(2, 0);
    tick(1, 16'h8000, 0, 0, 0, 0, 1);
    idle(3, 0);
    check_val("dir_sat_lo", 32'(out_data), 32'h8000);
    check_val("dir_sat_cnt2", 32'(sat_count), 32'd2);

    // forced apply after 64 busy cycles
    tick(0, 0, 1, 16'h8000, 0, 0, 1);
    idle(2, 0);
    for (int i = 0; i < 10; i++) tick(1, $urandom_range(0, 65535), 0, 0, 0, 0, 1);
    pend_n = 0;
    tick(1, $urandom_range(0, 65535), 1, 16'h4000, 0, 0, 1);
    if (cfg_pending) pend_n++;
    for (int i = 0; i < 75; i++) begin
      tick(1, $urandom_range(0, 65535), 0, 0, 0, 0, 1);
      if (cfg_pending) pend_n++;
    end
    check_val("dir_pend_cycles", 32'(pend_n), 32'd64);

    // mute ramp down, hold, ramp up; then reversal at g=32
    tick(0, 0, 1, 16'h8000, 0, 0, 1);
    idle(2, 0);
    stream(100, 16'h4000, 1);
    check_val("dir_muted_out", 32'(out_data), 32'd0);
    check_val("dir_muted_state", 32'(mute_state), 32'd2);
    stream(80, 16'h4000, 0);
    check_val("dir_unmuted_out", 32'(out_data), 32'h4000);
    check_val("dir_active_state", 32'(mute_state), 32'd0);
    stream(32, 16'h4000, 1);
    check_val("dir_mid_muting", 32'(mute_state), 32'd1);
    stream(1, 16'h4000, 0);
    check_val("dir_reverse", 32'(mute_state), 32'd3);
    stream(70, 16'h4000, 0);

    // random traffic, config updates, mute toggles and occasional resets
    lp_lvl = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) lp_lvl = ~lp_lvl;
      v   = ($urandom_range(0, 3) != 0);
      upd = ($urandom_range(0, 29) == 0);
      a   = ($urandom_range(0, 3) == 0) ? $urandom_range(32768, 65535) : $urandom_range(0, 32768);
      o   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 2047) - 1024;
      tick(v, $urandom_range(0, 65535), upd, a, o, lp_lvl, ($urandom_range(0, 399) != 0));
    end

    // reset in mid-stream
    idle(70, 0);
    tick(0, 0, 1, 16'h8000, 16'h7000, 0, 1);
    idle(2, 0);
    stream(10, 16'h4000, 0);
    tick(1, 16'h4000, 0, 0, 0, 0, 0);
    check_val("dir_rst_valid", 32'(out_valid), 32'd0);
    check_val("dir_rst_satcnt", 32'(sat_count), 32'd0);
    stream(3, 16'h1000, 0);
    check_val("dir_rst_gap", 32'(out_valid), 32'd0);
    stream(2, 16'h1000, 0);
    check_val("dir_resume", 32'(out_valid), 32'd1);
    check_val("dir_resume_data", 32'(out_data), 32'h1000);
    idle(6, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
